// File: rtl/reg_file_sb_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared constants for the scoreboarded register file and its neighbours:
//   XLEN_DEF / NREGS_DEF  default data width and architectural register count
//   OP_RTYPE              R-type opcode; decode drives use_imm = (opcode != OP_RTYPE)
//   rst_init_e            reset-init modes for the RESET_INDEX parameter
//   is_imm_op()           helper used by decode to derive use_imm
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  typedef enum int {
    RST_INIT_ZERO  = 0,
    RST_INIT_INDEX = 1
  } rst_init_e;

  function automatic logic is_imm_op(input logic [6:0] opcode);
    return opcode != OP_RTYPE;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the issue handshake, write-back port, read addresses and operand
// outputs of the register file.
//   master : decode/issue + write-back side (drives addresses, issue, wb)
//   slave  : the register file (drives op1/op2, issue_ready, busy_vec)
// ---------------------------------------------------------------------------
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
);

  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            use_imm;
  logic [XLEN-1:0] imm_in;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_wr;
  logic            issue_ready;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output rs1, rs2, use_imm, imm_in,
    output issue_valid, issue_rd, issue_wr,
    output wb_en, wb_rd, wb_data,
    input  issue_ready, op1, op2, busy_vec
  );

  modport slave (
    input  rs1, rs2, use_imm, imm_in,
    input  issue_valid, issue_rd, issue_wr,
    input  wb_en, wb_rd, wb_data,
    output issue_ready, op1, op2, busy_vec
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy bits plus the hazard check that produces issue_ready.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   rs1, rs2, use_imm         source operands of the issuing instruction
//   issue_valid/rd/wr         issue request; accepted when valid & ready
//   issue_ready               combinational, independent of issue_valid
//   wb_en, wb_rd              write-back strobe and destination
//   busy_vec                  current busy bits
// ---------------------------------------------------------------------------
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic                     use_imm,
  input  logic                     issue_valid,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     issue_wr,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_rd,
  output logic                     issue_ready,
  output logic [NREGS-1:0]         busy_vec
);

  localparam int AW  = $clog2(NREGS);
  localparam bit BYP = (BYPASS != 0);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic wb_hit_rd;
  logic src1_busy;
  logic src2_busy;
  logic waw;
  logic ready_c;
  logic set_en;

  // A write-back only releases a source hazard when it is forwarded, but it
  // always resolves a WAW because the older producer is retiring this cycle.
  always_comb begin
    wb_hit_rs1 = wb_en && (wb_rd == rs1);
    wb_hit_rs2 = wb_en && (wb_rd == rs2);
    wb_hit_rd  = wb_en && (wb_rd == issue_rd);
    src1_busy  = busy_q[rs1] && !(BYP && wb_hit_rs1);
    src2_busy  = !use_imm && busy_q[rs2] && !(BYP && wb_hit_rs2);
    waw        = issue_wr && busy_q[issue_rd] && !wb_hit_rd;
    ready_c    = !(src1_busy || src2_busy || waw);
    set_en     = issue_valid && ready_c && issue_wr;
  end

  // Set takes priority over clear so a new producer issued in the same
  // cycle as the old one's write-back stays outstanding. Bit 0 never sets.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (set_en && (issue_rd == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wb_en && (wb_rd == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign issue_ready = ready_c;
  assign busy_vec    = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// XLEN x NREGS register file with two combinational read ports, one
// write-back port, hard-wired x0, optional write-to-read bypass, operand-2
// immediate select and a busy-bit scoreboard gating instruction issue.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   bus (slave)    read addresses, immediate, issue handshake, write-back,
//                  op1/op2 operands, issue_ready and busy_vec debug
// Parameters:
//   BYPASS         1 = same-cycle write-back forwarded to reads and hazards
//   RESET_INDEX    1 = reset loads reg[i] = i, 0 = reset loads zeros
// ---------------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int NREGS       = NREGS_DEF,
  parameter int BYPASS      = 1,
  parameter int RESET_INDEX = int'(RST_INIT_INDEX)
) (
  input logic         clk,
  input logic         reset_n,
  reg_file_sb_if.slave bus
);

  localparam bit BYP      = (BYPASS != 0);
  localparam bit INIT_IDX = (RESET_INDEX == int'(RST_INIT_INDEX));

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] op1_c;
  logic [XLEN-1:0] op2_reg_c;
  logic [XLEN-1:0] op2_c;

  // Writes to x0 are dropped so its storage stays zero forever.
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en && (bus.wb_rd != '0)) begin
      regs_d[bus.wb_rd] = bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (INIT_IDX && (i != 0)) ? XLEN'(i) : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: x0 reads zero, a matching write-back is forwarded when
  // bypass is enabled, otherwise the stored value is returned.
  always_comb begin
    op1_c     = '0;
    op2_reg_c = '0;
    if (bus.rs1 != '0) begin
      if (BYP && bus.wb_en && (bus.wb_rd == bus.rs1)) begin
        op1_c = bus.wb_data;
      end else begin
        op1_c = regs_q[bus.rs1];
      end
    end
    if (bus.rs2 != '0) begin
      if (BYP && bus.wb_en && (bus.wb_rd == bus.rs2)) begin
        op2_reg_c = bus.wb_data;
      end else begin
        op2_reg_c = regs_q[bus.rs2];
      end
    end
    op2_c = bus.use_imm ? bus.imm_in : op2_reg_c;
  end

  assign bus.op1 = op1_c;
  assign bus.op2 = op2_c;

  rf_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
    .use_imm     (bus.use_imm),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .issue_wr    (bus.issue_wr),
    .wb_en       (bus.wb_en),
    .wb_rd       (bus.wb_rd),
    .issue_ready (bus.issue_ready),
    .busy_vec    (bus.busy_vec)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Drives two register files (BYPASS=1/RESET_INDEX=1 and BYPASS=0/
// RESET_INDEX=0) with identical inputs. Each stimulus cycle pushes the
// expected outputs of both into a queue; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [1:0][31:0] op1;
    logic [1:0][31:0] op2;
    logic [1:0]       rdy;
    logic [1:0][31:0] busy;
    logic [15:0]      step;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs1, rs2, issue_rd, wb_rd;
  logic        use_imm, issue_valid, issue_wr, wb_en;
  logic [31:0] imm_in, wb_data;

  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus0 ();
  reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus1 ();

  // Both buses see the same inputs.
  assign bus0.rs1 = rs1;          assign bus1.rs1 = rs1;
  assign bus0.rs2 = rs2;          assign bus1.rs2 = rs2;
  assign bus0.use_imm = use_imm;  assign bus1.use_imm = use_imm;
  assign bus0.imm_in = imm_in;    assign bus1.imm_in = imm_in;
  assign bus0.issue_valid = issue_valid;  assign bus1.issue_valid = issue_valid;
  assign bus0.issue_rd = issue_rd;        assign bus1.issue_rd = issue_rd;
  assign bus0.issue_wr = issue_wr;        assign bus1.issue_wr = issue_wr;
  assign bus0.wb_en = wb_en;      assign bus1.wb_en = wb_en;
  assign bus0.wb_rd = wb_rd;      assign bus1.wb_rd = wb_rd;
  assign bus0.wb_data = wb_data;  assign bus1.wb_data = wb_data;

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1), .RESET_INDEX(1)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0), .RESET_INDEX(0)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  logic [31:0] act_op1  [2];
  logic [31:0] act_op2  [2];
  logic        act_rdy  [2];
  logic [31:0] act_busy [2];
  assign act_op1[0] = bus0.op1;           assign act_op1[1] = bus1.op1;
  assign act_op2[0] = bus0.op2;           assign act_op2[1] = bus1.op2;
  assign act_rdy[0] = bus0.issue_ready;   assign act_rdy[1] = bus1.issue_ready;
  assign act_busy[0] = bus0.busy_vec;     assign act_busy[1] = bus1.busy_vec;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: architectural register contents and outstanding
  // producers, one set per DUT configuration.
  logic [31:0] m_regs [2][NREGS];
  bit          m_busy [2][NREGS];
  int          m_byp  [2] = '{1, 0};
  int          m_ri   [2] = '{1, 0};

  exp_t exp_q [$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[d][i] = (m_ri[d] != 0 && i != 0) ? 32'(i) : 32'd0;
        m_busy[d][i] = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] m_fwd(input int d, input int r);
    if (r == 0) return 32'd0;
    if (m_byp[d] != 0 && wb_en && int'(wb_rd) == r) return wb_data;
    return m_regs[d][r];
  endfunction

  function automatic logic m_ready(input int d);
    bit fwd_ok1, fwd_ok2, s1, s2, w;
    fwd_ok1 = (m_byp[d] != 0) && wb_en && (int'(wb_rd) == int'(rs1));
    fwd_ok2 = (m_byp[d] != 0) && wb_en && (int'(wb_rd) == int'(rs2));
    s1 = m_busy[d][int'(rs1)] && !fwd_ok1;
    s2 = !use_imm && m_busy[d][int'(rs2)] && !fwd_ok2;
    w  = issue_wr && m_busy[d][int'(issue_rd)] && !(wb_en && int'(wb_rd) == int'(issue_rd));
    return !(s1 || s2 || w);
  endfunction

  function automatic logic [31:0] m_busyvec(input int d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[d][i];
    return v;
  endfunction

  function automatic void m_update(input int d, input bit rdy);
    if (wb_en && wb_rd != 5'd0) m_regs[d][int'(wb_rd)] = wb_data;
    if (wb_en) m_busy[d][int'(wb_rd)] = 1'b0;
    if (issue_valid && rdy && issue_wr && issue_rd != 5'd0) m_busy[d][int'(issue_rd)] = 1'b1;
  endfunction

  function automatic exp_t m_expect(input int step);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e.op1[d]  = m_fwd(d, int'(rs1));
      e.op2[d]  = use_imm ? imm_in : m_fwd(d, int'(rs2));
      e.rdy[d]  = m_ready(d);
      e.busy[d] = m_busyvec(d);
    end
    e.step = 16'(step);
    return e;
  endfunction

  // Called at posedge+1: queue the expectation for the current inputs,
  // then advance the model across the next rising edge.
  task automatic applyStimulus(input int step);
    exp_t e;
    e = m_expect(step);
    exp_q.push_back(e);
    @(posedge clk);
    if (reset_n) begin
      for (int d = 0; d < 2; d++) m_update(d, e.rdy[d]);
    end
    #1;
  endtask

  // Asynchronous reset asserted and released away from any clock edge.
  task automatic doReset(input int step);
    wb_en       = 1'b0;
    issue_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    m_reset();
    exp_q.push_back(m_expect(step));
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int d, input int step,
                     input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d step %0d: got %h expected %h", name, d, step, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    for (int d = 0; d < 2; d++) begin
      cmp("op1", d, int'(e.step), act_op1[d], e.op1[d]);
      cmp("op2", d, int'(e.step), act_op2[d], e.op2[d]);
      cmp("issue_ready", d, int'(e.step), {31'd0, act_rdy[d]}, {31'd0, e.rdy[d]});
      cmp("busy_vec", d, int'(e.step), act_busy[d], e.busy[d]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checkOutput(mon_e);
    end
  end

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic idle();
    issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = 5'd0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    use_imm = 1'b0; imm_in = 32'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int step;
    logic [6:0] opc;
    step = 0;
    reset_n = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0;
    idle();
    m_reset();
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset: make something busy, then async reset with rs1=5, rs2=31.
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd5;
    applyStimulus(step++);
    idle(); rs1 = 5'd5; rs2 = 5'd31;
    doReset(step++);
    applyStimulus(step++);

    // x0: write-back to x0 ignored, issue to x0 never sets busy.
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF; rs1 = 5'd0;
    applyStimulus(step++);
    idle();
    applyStimulus(step++);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd0;
    applyStimulus(step++);
    idle();
    applyStimulus(step++);

    // RAW stall on x7, resolved by write-back of 0x1234.
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7; rs1 = 5'd0; rs2 = 5'd0;
    applyStimulus(step++);
    issue_wr = 1'b0; issue_rd = 5'd0; rs1 = 5'd7;
    repeat (3) applyStimulus(step++);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_1234;
    applyStimulus(step++);
    wb_en = 1'b0;
    applyStimulus(step++);
    applyStimulus(step++);

    // Immediate select hides a busy rs2.
    idle(); rs1 = 5'd0;
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd4;
    applyStimulus(step++);
    issue_wr = 1'b0; issue_rd = 5'd0; rs2 = 5'd4;
    use_imm = is_imm_op(7'b0010011); imm_in = 32'hFFFF_FFF0;
    applyStimulus(step++);
    use_imm = is_imm_op(OP_RTYPE);
    applyStimulus(step++);

    // Simultaneous set and clear of x9.
    idle(); rs1 = 5'd0; rs2 = 5'd0;
    doReset(step++);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd9;
    applyStimulus(step++);
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5_0009; rs1 = 5'd1; rs2 = 5'd2;
    applyStimulus(step++);
    idle(); rs1 = 5'd9;
    applyStimulus(step++);

    // WAW stall on x3, then reset abort and re-issue.
    idle(); rs1 = 5'd0; rs2 = 5'd0;
    doReset(step++);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
    applyStimulus(step++);
    applyStimulus(step++);
    rs1 = 5'd3;
    doReset(step++);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
    applyStimulus(step++);
    idle();
    applyStimulus(step++);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 400; i++) begin
      rs1 = pick_reg(); rs2 = pick_reg();
      opc = ($urandom_range(0, 1) == 0) ? OP_RTYPE : 7'b0010011;
      use_imm = is_imm_op(opc);
      imm_in = $urandom();
      issue_valid = 1'($urandom_range(0, 1));
      issue_wr = ($urandom_range(0, 3) != 0);
      issue_rd = pick_reg();
      wb_en = ($urandom_range(0, 2) != 0);
      wb_rd = pick_reg();
      wb_data = $urandom();
      if ($urandom_range(0, 63) == 0) doReset(step++);
      else applyStimulus(step++);
    end

    idle();
    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("[TB] FAIL drain: got %0d queued expected 0", exp_q.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-cycle register memory.
- Provides an XLEN x NREGS register file with:
  - two combinational read ports;
  - one write-back port;
  - a hard-wired zero register;
  - optional write-to-read bypass;
  - per-register busy scoreboard with a valid/ready issue handshake.
- Sits between decode/issue and ALU operand muxing; the operand-2 register/immediate select lives inside the block.

Parameters:
- XLEN, 32, data width of each register and of the immediate input.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- AW, $clog2(NREGS), register address width; derived, not overridden.
- BYPASS, 1, 1 = a same-cycle write-back is forwarded to read ports and to hazard checks; 0 = no forwarding.
- RESET_INDEX, 1, 1 = reset loads reg[i] = i (team bring-up convention); 0 = reset loads all zeros.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rs1  in  AW  source register 1 address
- rs2  in  AW  source register 2 address
- use_imm  in  1  1 = op2 is imm_in; 0 = op2 is reg[rs2]
- imm_in  in  XLEN  already sign-extended immediate
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rd  in  AW  destination of the issuing instruction
- issue_wr  in  1  issuing instruction will write issue_rd
- issue_ready  out  1  no hazard; instruction accepted when issue_valid & issue_ready
- wb_en  in  1  write-back strobe
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back value
- op1  out  XLEN  operand 1
- op2  out  XLEN  operand 2
- busy_vec  out  NREGS  current scoreboard bits, for debug

Behaviour:
- Reset (reset_n low, asynchronous):
  - reg[0] = 0; reg[i] = i (RESET_INDEX=1) or 0 (RESET_INDEX=0) for i >= 1;
  - busy_vec = 0;
  - issue_ready therefore reads 1 during and after reset.
- Reset asserted mid-operation discards all pending busy bits. In-flight write-backs arriving after reset release are written normally and clear nothing.
- Register 0:
  - reads always return 0;
  - writes are ignored;
  - busy[0] is never set.
- Reads are combinational, zero latency.
- op1 = fwd(rs1).
- op2 = use_imm ? imm_in : fwd(rs2).
- fwd(r):
  - returns 0 if r == 0;
  - else returns wb_data if BYPASS & wb_en & wb_rd == r;
  - else returns reg[r].
- Write: on the rising clk edge with wb_en and wb_rd != 0, reg[wb_rd] <= wb_data.
- Scoreboard, next-state per register r != 0:
  - set if (issue_valid & issue_ready & issue_wr & issue_rd == r);
  - else clear if (wb_en & wb_rd == r);
  - else hold.
  - If issue and write-back hit the same r in the same cycle, set wins: the new producer is outstanding.
- Hazard:
  - src1_busy = busy[rs1] & !(BYPASS & wb_en & wb_rd == rs1);
  - src2_busy = !use_imm & busy[rs2] & !(BYPASS & wb_en & wb_rd == rs2);
  - waw = issue_wr & busy[issue_rd] & !(wb_en & wb_rd == issue_rd).
  - issue_ready = !(src1_busy | src2_busy | waw).
  - issue_ready is combinational and independent of issue_valid.
- With BYPASS=0, a register being written back this cycle is still busy for reads. It becomes readable the next cycle.
- A write-back to a non-busy register is legal: data is written, scoreboard is unchanged.
- No state machine beyond busy bits. All outputs are glitch-free functions of state and inputs; no extra pipeline stage.

Decomposition:
- Shared package reg_file_pkg holds:
  - default XLEN/NREGS constants;
  - the opcode constant OP_RTYPE = 7'b0110011, used by decode to drive use_imm = (opcode != OP_RTYPE);
  - the reset-init mode constants.
- One natural sub-module: rf_scoreboard. It holds the busy-bit array, the set/clear logic and the hazard/issue_ready computation. The top instantiates it beside the storage array and the forwarding muxes.

Test Plan:
- Reset: pulse reset_n low asynchronously mid-cycle, then set rs1=5, rs2=31, use_imm=0 -> op1=5, op2=31, busy_vec=0, issue_ready=1; with RESET_INDEX=0, op1=0 and op2=0.
- x0 rule: wb_en, wb_rd=0, wb_data=32'hDEAD_BEEF, then rs1=0 -> op1=0; issue rd=0 with issue_wr=1 -> busy_vec stays 0.
- Scoreboard RAW stall: issue rd=7 (accepted), next cycle rs1=7 -> issue_ready=0. Hold 3 cycles, then wb_en, wb_rd=7, wb_data=32'h1234:
  - BYPASS=1: issue_ready=1 and op1=32'h1234 in that same cycle, busy[7] clears next edge;
  - BYPASS=0: issue_ready=0 that cycle, 1 the next cycle with op1=32'h1234.
- Immediate select: rs2 busy, use_imm=1, imm_in=32'hFFFF_FFF0 -> issue_ready=1, op2=32'hFFFF_FFF0.
- Simultaneous set/clear: busy[9]=1; in one cycle wb_rd=9 and issue accepted with issue_rd=9 and a source other than 9 -> reg[9]=wb_data, busy[9] remains 1.
- WAW stall and reset abort: issue rd=3, then issue rd=3 again -> issue_ready=0. Assert reset_n=0 for one cycle -> busy_vec=0, reg[3]=3, and the second issue is accepted after release.
